fifo_read_arbiter: RTL and testbench

- Shares the single read port of the dual-clock FIFO among NUM_REQ consumers in the read clock domain.
- Arbitrates round-robin and holds the grant for a burst of up to MAX_BURST words.
- Drives the FIFO pop strobe and captures the popped word into a registered, per-requester-tagged output.
- Sits between the FIFO read-pointer/empty logic plus the memory read port and the downstream consumers.

---
 rtl/fifo_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_read_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// Round-robin sharing of one FIFO read port among NUM_REQ consumers, granting bursts of up to MAX_BURST pops.
// rinc is combinational in the pop cycle; dout/dvalid are registered one cycle after the pop.
// Pops only while the owner requests and the FIFO is non-empty; one idle bubble separates grants. FIFO_ARB_STATS_EN adds pop_count.
module fifo_read_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [DATA_SIZE-1:0] dout,
  output logic [NUM_REQ-1:0]   dvalid
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] pop_count
`endif
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   dvalid_q, dvalid_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;

  logic                 sel_vld;
  logic [OW-1:0]        sel_idx;
  logic [OW-1:0]        cand;
  logic [BW-1:0]        beat_inc;
  logic [NUM_REQ-1:0]   owner_oh;

  // Round-robin pick: first requester found searching upward from last+1, wrapping modulo NUM_REQ.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(last_q) + k) % NUM_REQ);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Grant FSM next state, pop strobe and output capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    beat_d   = beat_q;
    gnt_d    = gnt_q;
    dout_d   = dout_q;
    dvalid_d = '0;
    beat_inc = beat_q + BW'(1);
    owner_oh = NUM_REQ'(1) << owner_q;
    // Suppressed during reset so a burst cut by reset never pops a word that would be lost.
    rinc     = (state_q == BURST) && req[owner_q] && !rempty && !rrst;

    case (state_q)
      IDLE: begin
        if (sel_vld && !rempty) begin
          state_d = BURST;
          owner_d = sel_idx;
          gnt_d   = NUM_REQ'(1) << sel_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (rinc) begin
          dout_d   = rdata;
          dvalid_d = owner_oh;
          beat_d   = beat_inc;
        end
        if ((rinc && beat_inc == BW'(MAX_BURST)) || !req[owner_q] || rempty) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; last pointer resets so requester 0 wins first.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= OW'(NUM_REQ - 1);
      beat_q   <= '0;
      gnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] cnt_q, cnt_d;

  // Per-requester saturating pop counters, updated alongside dvalid.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rinc && owner_q == OW'(i) && cnt_q[16*i +: 16] != 16'hFFFF) begin
        cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Randomized and directed checking of fifo_read_arbiter against a transaction-level model.
// Inputs driven on the falling edge; outputs checked 1 time unit later.
// FIFO contents modelled as a queue; rempty follows queue occupancy or a random forced-empty.
module tb_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         rclk = 1'b0;
  logic         rrst = 1'b1;
  logic [N-1:0] req = '0;
  logic         rempty = 1'b1;
  logic [W-1:0] rdata = '0;
  logic         rinc;
  logic [N-1:0] gnt;
  logic [W-1:0] dout;
  logic [N-1:0] dvalid;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] pop_count;
`endif

  fifo_read_arbiter #(.NUM_REQ(N), .DATA_SIZE(W), .MAX_BURST(MB)) dut (
    .rclk(rclk),
    .rrst(rrst),
    .req(req),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .gnt(gnt),
    .dout(dout),
    .dvalid(dvalid)
`ifdef FIFO_ARB_STATS_EN
    ,
    .pop_count(pop_count)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: grant owner (-1 = none), last owner, pops in current grant.
  int           m_owner = -1;
  int           m_last  = N - 1;
  int           m_beats = 0;
  logic [N-1:0] m_dvalid = '0;
  logic [W-1:0] m_dout = '0;
  int           m_cnt[N];
  logic [W-1:0] fifo[$];

  bit           log_en = 0;
  logic [N-1:0] prev_gnt = '0;
  int           order[$];
  int           vld_count = 0;

  task automatic cycle(input logic [N-1:0] r, input bit rst, input bit fe);
    bit           emp, pop, found;
    logic [W-1:0] d;
    logic [N-1:0] eg;
    int           idx;
    @(negedge rclk);
    emp    = fe || (fifo.size() == 0);
    req    = r;
    rrst   = rst;
    rempty = emp;
    d      = (fifo.size() != 0) ? fifo[0] : W'($urandom);
    rdata  = d;
    #1;
    pop = !rst && (m_owner >= 0) && r[m_owner] && !emp;
    eg  = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("rinc", rinc, pop);
    check("gnt", gnt, eg);
    check("dvalid", dvalid, m_dvalid);
    check("dout", dout, m_dout);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("pop_count", pop_count[16*i +: 16], m_cnt[i]);
`endif
    if (log_en && gnt != 0 && prev_gnt == 0)
      for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
    prev_gnt = gnt;
    if (dvalid != 0) vld_count++;

    @(posedge rclk);
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_beats = 0;
      m_dvalid = '0; m_dout = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_owner < 0) begin
      m_dvalid = '0;
      if (r != 0 && !emp) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && r[idx]) begin
            found = 1; m_owner = idx;
          end
        end
        m_beats = 0;
      end
    end else begin
      m_dvalid = '0;
      if (pop) begin
        m_dout = d;
        m_dvalid[m_owner] = 1'b1;
        m_beats++;
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
      end
      if ((pop && m_beats == MB) || !r[m_owner] || emp) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end
    if (pop) void'(fifo.pop_front());
  endtask

  logic [N-1:0] rq;
  int           exp_order[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // Reset with everyone requesting and FIFO empty.
    cycle(4'b1111, 1, 1);
    cycle(4'b1111, 1, 1);
    cycle(4'b1111, 0, 1);

    // Single requester, six words: bursts of 4 then 2.
    for (int i = 0; i < 6; i++) fifo.push_back(W'(8'h11 + i));
    vld_count = 0;
    for (int i = 0; i < 14; i++) cycle(4'b0100, 0, 0);
    check("burst_pops", vld_count, 6);

    // Round-robin order from reset with req=1011 and a deep FIFO.
    cycle(4'b0000, 1, 0);
    for (int i = 0; i < 40; i++) fifo.push_back(W'($urandom));
    order.delete();
    log_en = 1;
    for (int i = 0; i < 34; i++) cycle(4'b1011, 0, 0);
    log_en = 0;
    check("rr_grants", order.size() >= 6, 1);
    for (int i = 0; i < 6 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);

    // Early release: requester 2 drops after two pops while requester 0 waits.
    cycle(4'b0000, 1, 0);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 0, 0);
    for (int i = 0; i < 8; i++) cycle(4'b0001, 0, 0);

    // FIFO drains mid-burst, then one word refilled.
    cycle(4'b0000, 1, 0);
    fifo.delete();
    fifo.push_back(8'hA1);
    fifo.push_back(8'hA2);
    for (int i = 0; i < 6; i++) cycle(4'b0001, 0, 0);
    fifo.push_back(8'hA3);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 0, 0);

    // Reset landing in a dvalid cycle mid-burst, then a fresh burst.
    for (int i = 0; i < 8; i++) fifo.push_back(W'($urandom));
    cycle(4'b0010, 0, 0);
    cycle(4'b0010, 0, 0);
    cycle(4'b0010, 0, 0);
    cycle(4'b0010, 1, 0);
    for (int i = 0; i < 7; i++) cycle(4'b0010, 0, 0);

    // Random traffic.
    rq = 4'b1011;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      if (fifo.size() < 48)
        for (int p = $urandom_range(0, 2); p > 0; p--) fifo.push_back(W'($urandom));
      cycle(rq, $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
